carregador_instrucoes: RTL
==========================

// Module: carregador_instrucoes
// PURPOSE
// - Write-side loader for the 256x8 instruction memory: receives a framed byte stream and writes it into memory.
// - Stream arrives over a valid/ready handshake. Memory writes land on posedge; the memory reads on negedge.
// - Holds the CPU stalled while a load is in progress. Reports done/error and a checksum verdict.
// PARAMETERS
// - ADDR_W          8       memory address width; address wraps modulo 2**ADDR_W
// - DATA_W          8       instruction/byte width
// - SYNC_BYTE       8'hA5   frame header value
// - TIMEOUT_CYCLES  1024    max idle cycles between bytes inside a frame (only with CARREGADOR_TIMEOUT_EN)
// PORTS
// - clock      in   1       single clock, all logic on posedge
// - reset      in   1       synchronous, active-low
// - rx_dado    in   DATA_W  incoming stream byte
// - rx_valido  in   1       rx_dado valid
// - rx_pronto  out  1       loader accepts byte; transfer = rx_valido & rx_pronto
// - mem_we     out  1       memory write enable, one-cycle pulse per data byte
// - mem_end    out  ADDR_W  write address
// - mem_dado   out  DATA_W  write data
// - cpu_hold   out  1       1 while a frame is in progress (ADDR..CHECK states)
// - carga_ok   out  1       1-cycle pulse: frame finished, checksum matched
// - carga_erro out  1       sticky: frame failed; cleared by a new SYNC_BYTE or reset
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE; rx_pronto=0, mem_we=0, mem_end=0, mem_dado=0, cpu_hold=0, carga_ok=0, carga_erro=0, checksum=0.
//   Reset mid-frame aborts the frame immediately. Bytes already written stay in memory.
// - rx_pronto=1 in IDLE, ADDR, LEN, DATA and CHECK. It is 0 in the cycle after reset and in OK.
// - Frame: SYNC_BYTE, start address A, length L (L==0 means 256), L data bytes, checksum C.
// - Checksum: running XOR of A, L and every data byte. Any C != running XOR means error.
// - FSM, advancing only on transfer cycles:
//   - IDLE: byte==SYNC_BYTE -> ADDR, clear carga_erro and checksum. Other bytes are discarded.
//   - ADDR: ptr=A, csum^=A -> LEN.
//   - LEN: cnt=L (9-bit, 0 maps to 256), csum^=L -> DATA.
//   - DATA: mem_we=1 next cycle with mem_end=ptr, mem_dado=byte; ptr=ptr+1 (wraps 255->0); cnt-=1; cnt reaching 0 -> CHECK.
//   - CHECK: C==csum -> OK; else -> IDLE with carga_erro=1.
//   - OK: carga_ok=1 for one cycle -> IDLE.
// - Write latency: mem_we is asserted on the cycle after the data byte's transfer cycle, registered. Back-to-back bytes give back-to-back writes.
// - cpu_hold is registered: it rises the cycle after the SYNC_BYTE transfer and falls the cycle after leaving CHECK.
// - A SYNC_BYTE value inside ADDR/LEN/DATA/CHECK is treated as ordinary data, not as a restart.
// - Wrap: A=8'hFE, L=3 writes addresses FE, FF, 00.
// - rx_valido deasserted mid-frame: the loader waits indefinitely (unless the timeout is enabled).
// CONFIGURATION
// - CARREGADOR_TIMEOUT_EN defined:
//   - A 16-bit idle counter runs in ADDR..CHECK and resets on every transfer.
//   - Reaching TIMEOUT_CYCLES -> IDLE, carga_erro=1, cpu_hold drops the next cycle, no further writes.
// - CARREGADOR_TIMEOUT_EN undefined: no counter, no timeout; a stalled frame holds the CPU forever.
// TESTING
// - Stream A5,10,02,3C,C3,(10^02^3C^C3)=ED -> writes mem[10]=3C, mem[11]=C3; carga_ok pulse; carga_erro=0; cpu_hold back to 0.
// - Same frame with checksum 00 -> both writes occur; no carga_ok; carga_erro=1 and stays until the next A5.
// - A5,FE,03,11,22,33,csum -> writes at FE, FF, 00 in order; carga_ok.
// - L=00 with 256 data bytes from A=00 -> exactly 256 mem_we pulses over addresses 00..FF; carga_ok after the checksum.
// - Reset driven low during DATA after 2 of 4 bytes -> next cycle all outputs at reset values; a fresh frame then loads correctly.
// - With CARREGADOR_TIMEOUT_EN and TIMEOUT_CYCLES=16: stop valid after LEN for 16 cycles -> carga_erro=1, state IDLE, no mem_we.

Source files
------------

// File: rtl/carregador_instrucoes.sv
// Write-side loader for the instruction memory: parses SYNC/ADDR/LEN/DATA/CHECK frames.
// Optional idle-timeout inside a frame is enabled by defining CARREGADOR_TIMEOUT_EN.
module carregador_instrucoes #(
    parameter int          ADDR_W         = 8,
    parameter int          DATA_W         = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_dado,
    input  logic              rx_valido,
    output logic              rx_pronto,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_end,
    output logic [DATA_W-1:0] mem_dado,
    output logic              cpu_hold,
    output logic              carga_ok,
    output logic              carga_erro
);
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CHECK, OK} estado_t;

    estado_t           estado;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W:0]   cnt;
    logic [DATA_W-1:0] csum;
    logic              xfer;
`ifdef CARREGADOR_TIMEOUT_EN
    logic [15:0]       ociosos;
`endif

    assign xfer = rx_valido & rx_pronto;

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado     <= IDLE;
            rx_pronto  <= 1'b0;
            mem_we     <= 1'b0;
            mem_end    <= '0;
            mem_dado   <= '0;
            cpu_hold   <= 1'b0;
            carga_ok   <= 1'b0;
            carga_erro <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
            csum       <= '0;
`ifdef CARREGADOR_TIMEOUT_EN
            ociosos    <= '0;
`endif
        end else begin
            mem_we    <= 1'b0;
            carga_ok  <= 1'b0;
            rx_pronto <= 1'b1;
            case (estado)
                IDLE: if (xfer && rx_dado == DATA_W'(SYNC_BYTE)) begin
                    estado     <= ADDR;
                    carga_erro <= 1'b0;
                    csum       <= '0;
                    cpu_hold   <= 1'b1;
                end
                ADDR: if (xfer) begin
                    ptr    <= ADDR_W'(rx_dado);
                    csum   <= csum ^ rx_dado;
                    estado <= LEN;
                end
                LEN: if (xfer) begin
                    // A zero length encodes a full 2**DATA_W byte block
                    cnt    <= (rx_dado == '0) ? (DATA_W+1)'(1 << DATA_W) : {1'b0, rx_dado};
                    csum   <= csum ^ rx_dado;
                    estado <= DATA;
                end
                DATA: if (xfer) begin
                    mem_we   <= 1'b1;
                    mem_end  <= ptr;
                    mem_dado <= rx_dado;
                    ptr      <= ptr + 1'b1;
                    csum     <= csum ^ rx_dado;
                    cnt      <= cnt - 1'b1;
                    if (cnt == (DATA_W+1)'(1))
                        estado <= CHECK;
                end
                CHECK: if (xfer) begin
                    cpu_hold <= 1'b0;
                    if (rx_dado == csum) begin
                        estado    <= OK;
                        carga_ok  <= 1'b1;
                        rx_pronto <= 1'b0;
                    end else begin
                        estado     <= IDLE;
                        carga_erro <= 1'b1;
                    end
                end
                OK:      estado <= IDLE;
                default: estado <= IDLE;
            endcase
`ifdef CARREGADOR_TIMEOUT_EN
            // Idle counter only matters mid-frame; any accepted byte restarts it
            if (estado == IDLE || estado == OK || xfer) begin
                ociosos <= '0;
            end else if (ociosos == 16'(TIMEOUT_CYCLES - 1)) begin
                ociosos    <= '0;
                estado     <= IDLE;
                carga_erro <= 1'b1;
                cpu_hold   <= 1'b0;
            end else begin
                ociosos <= ociosos + 1'b1;
            end
`endif
        end
    end
endmodule
